regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised multi-read-port register file with per-register busy scoreboard, write-to-read bypass, and a configurable hard-wired zero register. It is the next-generation general-purpose register file for the CPU datapath. Decode reads operands and checks pending writes through it, and writeback commits results to it. Register width, depth, read-port count, zero-register index and bypass are all set at elaboration time.

## Interface

Parameters:
- WIDTH, default 64: bits per register.
- DEPTH, default 32: number of registers, power of two, ≥2.
- NREAD, default 2: number of read ports, 1–4.
- ZERO_REG, default 31: index that always reads 0; writes to it are discarded and it never becomes busy. Set to DEPTH to disable.
- BYPASS, default 1: 1 = same-cycle write data is forwarded to matching reads; 0 = reads see only stored state.
- Derived localparam AW = $clog2(DEPTH).

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- RegWrite, input, 1: write enable.
- WriteRegister, input, AW: write index.
- WriteData, input, WIDTH: write data.
- ReadRegister, input, NREAD*AW: read indices, port i at [i*AW +: AW].
- ReadData, output, NREAD*WIDTH: read data, port i at [i*WIDTH +: WIDTH].
- ReadBusy, output, NREAD: port i's register has an outstanding producer.
- MarkBusy, input, 1: set busy for MarkRegister (issue of a producing instruction).
- MarkRegister, input, AW: index to mark.
- AnyBusy, output, 1: OR of all busy bits.

## Operation

- Storage: DEPTH×WIDTH flops plus a DEPTH-bit busy vector. The zero register has no storage, reads 0 and has busy forced to 0.
- Write: at a rising edge with RegWrite=1, reset=0 and WriteRegister≠ZERO_REG, reg[WriteRegister] ← WriteData. The same edge clears busy[WriteRegister].
- Mark: at a rising edge with MarkBusy=1, reset=0 and MarkRegister≠ZERO_REG, busy[MarkRegister] ← 1.
- Mark and write to the same index on the same edge: data is written and busy ends at 1, because the mark represents a newer producer. Mark and write to different indices act independently.
- Read (combinational), for each port i with index r:
  - If r==ZERO_REG, ReadData=0 and ReadBusy=0.
  - Else, if BYPASS=1, RegWrite=1 and WriteRegister==r, ReadData=WriteData and ReadBusy=0.
  - Otherwise ReadData=reg[r] and ReadBusy=busy[r].
- All read ports are independent. Any number may address the same register.
- AnyBusy is the OR of the registered busy vector only; there is no bypass term.
- Out-of-range indices are impossible because DEPTH is a power of two.

## Timing

- Reset: at a rising edge with reset=1, all registers become 0 and all busy bits become 0. RegWrite and MarkBusy are ignored on that edge.
- After reset: ReadData=0 on all ports, ReadBusy=0, AnyBusy=0.
- Reset asserted mid-sequence discards any write or mark presented in that cycle.
- Write-to-read latency:
  - BYPASS=1: 0 cycles, forwarded in the same cycle.
  - BYPASS=0: 1 cycle, visible after the edge.
- Mark-to-ReadBusy latency: 1 cycle. No same-cycle forwarding of MarkBusy.
- Clear-to-ReadBusy latency:
  - BYPASS=1: 0 cycles.
  - BYPASS=0: 1 cycle.
- The read path is purely combinational from ReadRegister, the stored state and the write port. There are no registered outputs.

## Test plan

- Reset, then read all indices on every port. Required: all ReadData=0, ReadBusy=0, AnyBusy=0.
- Write 0xDEADBEEF_CAFEF00D to r5; port 0 reads r5 in the same cycle.
  - BYPASS=1: same-cycle read returns 0xDEADBEEF_CAFEF00D.
  - BYPASS=0: same-cycle read returns 0; it returns the new value the next cycle.
  - Port 1 reads r6 in the same cycle: returns 0.
- Write 0xFFFF…F to ZERO_REG (31) with MarkBusy on 31, then read 31 on all ports. Required: ReadData=0, ReadBusy=0, AnyBusy=0.
- Busy sequence on r7:
  - Mark r7: the next cycle ReadBusy=1 and AnyBusy=1.
  - Write r7=0x42 with no mark: ReadBusy=0 and ReadData=0x42 (same cycle if BYPASS=1).
  - Mark and write r7 on the same edge: the following cycle ReadBusy=1 and ReadData=0x42.
- Fill r0–r30 with value i·0x0101…01, then assert reset together with a write of 0x99 to r3 and a mark of r4. Required: afterwards all registers read 0, no register is busy, and r3≠0x99.
- NREAD=4, WIDTH=32, DEPTH=16, ZERO_REG=0. All four ports read r9 after a write of 0x1234 to r9. Required: all four ports return 0x1234, and r0 reads 0.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with a per-register busy scoreboard, optional
// write-to-read bypass and an optional hard-wired zero register.
module regfile_multiport #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RegWrite,
    input  logic [AW-1:0]          WriteRegister,
    input  logic [WIDTH-1:0]       WriteData,
    input  logic [NREAD*AW-1:0]    ReadRegister,
    output logic [NREAD*WIDTH-1:0] ReadData,
    output logic [NREAD-1:0]       ReadBusy,
    input  logic                   MarkBusy,
    input  logic [AW-1:0]          MarkRegister,
    output logic                   AnyBusy
);

    // One extra bit so ZERO_REG == DEPTH never matches any real index.
    localparam logic [AW:0] ZERO_IDX = (AW+1)'(ZERO_REG);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        if (g == ZERO_REG) begin : g_zero
            assign regs[g] = '0;
            assign busy[g] = 1'b0;
        end else begin : g_store
            logic [WIDTH-1:0] q;
            logic             b;
            logic             wr_hit;
            logic             mark_hit;

            assign wr_hit   = RegWrite && (WriteRegister == AW'(g));
            assign mark_hit = MarkBusy && (MarkRegister == AW'(g));

            // A mark on the same edge as the write is a newer producer, so it wins.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                    b <= 1'b0;
                end else begin
                    if (wr_hit) q <= WriteData;
                    if (mark_hit) b <= 1'b1;
                    else if (wr_hit) b <= 1'b0;
                end
            end

            assign regs[g] = q;
            assign busy[g] = b;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0]    idx;
        logic [WIDTH-1:0] rd_data;
        logic             rd_busy;

        assign idx = ReadRegister[p*AW +: AW];

        always_comb begin
            rd_data = regs[idx];
            rd_busy = busy[idx];
            if ({1'b0, idx} == ZERO_IDX) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end else if ((BYPASS != 0) && RegWrite && (WriteRegister == idx)) begin
                rd_data = WriteData;
                rd_busy = 1'b0;
            end
        end

        assign ReadData[p*WIDTH +: WIDTH] = rd_data;
        assign ReadBusy[p]                = rd_busy;
    end

    assign AnyBusy = |busy;

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomized and directed bench for regfile_multiport: a bypassing and a
// non-bypassing default instance share inputs, plus a 4-port 16x32 instance.
module tb_regfile_multiport;
  localparam int W   = 64;
  localparam int AW  = 5;
  localparam int ZR  = 31;
  localparam int W2  = 32;
  localparam int AW2 = 4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // default-configuration inputs (shared by both bypass variants)
  logic          reg_write;
  logic [AW-1:0] write_register;
  logic [W-1:0]  write_data;
  logic [2*AW-1:0] read_register;
  logic          mark_busy;
  logic [AW-1:0] mark_register;
  logic [2*W-1:0] rd_b, rd_n;
  logic [1:0]    rb_b, rb_n;
  logic          ab_b, ab_n;

  // small-configuration inputs
  logic           s_reg_write;
  logic [AW2-1:0] s_write_register;
  logic [W2-1:0]  s_write_data;
  logic [4*AW2-1:0] s_read_register;
  logic           s_mark_busy;
  logic [AW2-1:0] s_mark_register;
  logic [4*W2-1:0] s_rd;
  logic [3:0]     s_rb;
  logic           s_ab;

  regfile_multiport #(.WIDTH(W), .DEPTH(32), .NREAD(2), .ZERO_REG(ZR), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .RegWrite(reg_write), .WriteRegister(write_register),
    .WriteData(write_data), .ReadRegister(read_register), .ReadData(rd_b),
    .ReadBusy(rb_b), .MarkBusy(mark_busy), .MarkRegister(mark_register), .AnyBusy(ab_b)
  );

  regfile_multiport #(.WIDTH(W), .DEPTH(32), .NREAD(2), .ZERO_REG(ZR), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .RegWrite(reg_write), .WriteRegister(write_register),
    .WriteData(write_data), .ReadRegister(read_register), .ReadData(rd_n),
    .ReadBusy(rb_n), .MarkBusy(mark_busy), .MarkRegister(mark_register), .AnyBusy(ab_n)
  );

  regfile_multiport #(.WIDTH(W2), .DEPTH(16), .NREAD(4), .ZERO_REG(0), .BYPASS(1)) u_small (
    .clk(clk), .reset(reset), .RegWrite(s_reg_write), .WriteRegister(s_write_register),
    .WriteData(s_write_data), .ReadRegister(s_read_register), .ReadData(s_rd),
    .ReadBusy(s_rb), .MarkBusy(s_mark_busy), .MarkRegister(s_mark_register), .AnyBusy(s_ab)
  );

  // ---------------- reference model ----------------
  logic [63:0] m_mem [32];
  logic        m_busy [32];
  logic [31:0] s_mem [16];
  logic        s_busy [16];

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
      for (int i = 0; i < 16; i++) begin s_mem[i] = '0; s_busy[i] = 1'b0; end
    end else begin
      if (reg_write && write_register != ZR) begin
        m_mem[write_register]  = write_data;
        m_busy[write_register] = 1'b0;
      end
      if (mark_busy && mark_register != ZR) m_busy[mark_register] = 1'b1;
      if (s_reg_write && s_write_register != 0) begin
        s_mem[s_write_register]  = s_write_data;
        s_busy[s_write_register] = 1'b0;
      end
      if (s_mark_busy && s_mark_register != 0) s_busy[s_mark_register] = 1'b1;
    end
  endtask

  function automatic logic [63:0] exp_data(int idx, bit bp);
    if (idx == ZR) return 64'd0;
    if (bp && reg_write && int'(write_register) == idx) return write_data;
    return m_mem[idx];
  endfunction

  function automatic logic exp_busy(int idx, bit bp);
    if (idx == ZR) return 1'b0;
    if (bp && reg_write && int'(write_register) == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  function automatic logic exp_any();
    logic a = 1'b0;
    for (int i = 0; i < 32; i++) a |= m_busy[i];
    return a;
  endfunction

  function automatic logic s_exp_any();
    logic a = 1'b0;
    for (int i = 0; i < 16; i++) a |= s_busy[i];
    return a;
  endfunction

  // ---------------- checking ----------------
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int p = 0; p < 2; p++) begin
      int idx = int'(read_register[p*AW +: AW]);
      exp_q.push_back(exp_data(idx, 1'b1));
      exp_q.push_back(exp_data(idx, 1'b0));
      exp_q.push_back(64'(exp_busy(idx, 1'b1)));
      exp_q.push_back(64'(exp_busy(idx, 1'b0)));
      check($sformatf("%s_p%0d_data_byp", tag, p), rd_b[p*W +: W], exp_q.pop_front());
      check($sformatf("%s_p%0d_data_nobyp", tag, p), rd_n[p*W +: W], exp_q.pop_front());
      check($sformatf("%s_p%0d_busy_byp", tag, p), 64'(rb_b[p]), exp_q.pop_front());
      check($sformatf("%s_p%0d_busy_nobyp", tag, p), 64'(rb_n[p]), exp_q.pop_front());
    end
    exp_q.push_back(64'(exp_any()));
    check({tag, "_any_byp"}, 64'(ab_b), exp_q[0]);
    check({tag, "_any_nobyp"}, 64'(ab_n), exp_q.pop_front());
  endtask

  task automatic s_check_all(string tag);
    for (int p = 0; p < 4; p++) begin
      int idx = int'(s_read_register[p*AW2 +: AW2]);
      logic [31:0] d;
      logic        b;
      if (idx == 0) begin d = '0; b = 1'b0; end
      else if (s_reg_write && int'(s_write_register) == idx) begin d = s_write_data; b = 1'b0; end
      else begin d = s_mem[idx]; b = s_busy[idx]; end
      exp_q.push_back(64'(d));
      exp_q.push_back(64'(b));
      check($sformatf("%s_p%0d_data", tag, p), 64'(s_rd[p*W2 +: W2]), exp_q.pop_front());
      check($sformatf("%s_p%0d_busy", tag, p), 64'(s_rb[p]), exp_q.pop_front());
    end
    exp_q.push_back(64'(s_exp_any()));
    check({tag, "_any"}, 64'(s_ab), exp_q.pop_front());
  endtask

  // ---------------- drivers ----------------
  task automatic drive(bit rst, bit wr, int wreg, logic [63:0] wd, bit mk, int mreg, int r0, int r1);
    @(negedge clk);
    reset          = rst;
    reg_write      = wr;
    write_register = AW'(wreg);
    write_data     = wd;
    mark_busy      = mk;
    mark_register  = AW'(mreg);
    read_register  = {AW'(r1), AW'(r0)};
    #1;
  endtask

  task automatic s_drive(bit wr, int wreg, logic [31:0] wd, bit mk, int mreg,
                         int r0, int r1, int r2, int r3);
    @(negedge clk);
    reset            = 1'b0;
    reg_write        = 1'b0;
    mark_busy        = 1'b0;
    s_reg_write      = wr;
    s_write_register = AW2'(wreg);
    s_write_data     = wd;
    s_mark_busy      = mk;
    s_mark_register  = AW2'(mreg);
    s_read_register  = {AW2'(r3), AW2'(r2), AW2'(r1), AW2'(r0)};
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    model_edge();
  endtask

  // ---------------- stimulus ----------------
  localparam logic [63:0] K_DEAD = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] K_REP  = 64'h0101_0101_0101_0101;

  initial begin
    reset = 1'b1;
    reg_write = 1'b0; write_register = '0; write_data = '0;
    read_register = '0; mark_busy = 1'b0; mark_register = '0;
    s_reg_write = 1'b0; s_write_register = '0; s_write_data = '0;
    s_read_register = '0; s_mark_busy = 1'b0; s_mark_register = '0;
    for (int i = 0; i < 32; i++) begin m_mem[i] = 'x; m_busy[i] = 1'bx; end
    for (int i = 0; i < 16; i++) begin s_mem[i] = 'x; s_busy[i] = 1'bx; end

    drive(1, 1, 3, 64'h55, 1, 4, 0, 0); commit();
    drive(1, 0, 0, 0, 0, 0, 0, 0); commit();

    // reset state on every index, every port
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 0, i, 31 - i);
      check_all("rst_read");
      check("rst_const_p0", rd_b[63:0], 64'd0);
      commit();
    end

    // write r5, read r5 and r6 in the same cycle
    drive(0, 1, 5, K_DEAD, 0, 0, 5, 6);
    check_all("w5");
    check("w5_byp_same", rd_b[63:0], K_DEAD);
    check("w5_nobyp_same", rd_n[63:0], 64'd0);
    check("r6_byp_same", rd_b[127:64], 64'd0);
    commit();
    drive(0, 0, 0, 0, 0, 0, 5, 6);
    check("w5_nobyp_next", rd_n[63:0], K_DEAD);
    commit();

    // zero register ignores write and mark
    drive(0, 1, 31, '1, 1, 31, 31, 31);
    check_all("zr_same");
    check("zr_byp_same", rd_b[63:0], 64'd0);
    commit();
    drive(0, 0, 0, 0, 0, 0, 31, 31);
    check_all("zr_next");
    check("zr_any", 64'(ab_b), 64'd0);
    check("zr_busy", 64'(rb_b), 64'd0);
    commit();

    // busy sequence on r7
    drive(0, 0, 0, 0, 1, 7, 7, 7);
    check_all("mk7_same");
    check("mk7_no_fwd", 64'(rb_b[0]), 64'd0);
    commit();
    drive(0, 0, 0, 0, 0, 0, 7, 7);
    check_all("mk7_next");
    check("mk7_busy", 64'(rb_b[0]), 64'd1);
    check("mk7_any", 64'(ab_b), 64'd1);
    commit();
    drive(0, 1, 7, 64'h42, 0, 0, 7, 7);
    check_all("w7_same");
    check("w7_byp_busy", 64'(rb_b[0]), 64'd0);
    check("w7_byp_data", rd_b[63:0], 64'h42);
    check("w7_nobyp_busy", 64'(rb_n[0]), 64'd1);
    commit();
    drive(0, 0, 0, 0, 0, 0, 7, 7);
    check_all("w7_next");
    check("w7_nobyp_clear", 64'(rb_n[0]), 64'd0);
    check("w7_nobyp_data", rd_n[63:0], 64'h42);
    commit();
    drive(0, 1, 7, 64'h42, 1, 7, 7, 7);
    check_all("wm7_same");
    commit();
    drive(0, 0, 0, 0, 0, 0, 7, 7);
    check_all("wm7_next");
    check("wm7_busy", 64'(rb_b[0]), 64'd1);
    check("wm7_data", rd_b[63:0], 64'h42);
    commit();

    // fill, then reset together with a write and a mark
    for (int i = 0; i < 31; i++) begin
      drive(0, 1, i, K_REP * 64'(i), 0, 0, i, 30 - i);
      check_all("fill");
      commit();
    end
    drive(1, 1, 3, 64'h99, 1, 4, 3, 4);
    commit();
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 0, i, (i + 1) % 32);
      check_all("post_rst");
      if (i == 3) check("post_rst_r3", rd_b[63:0], 64'd0);
      if (i == 4) check("post_rst_r4_busy", 64'(rb_b[0]), 64'd0);
      commit();
    end

    // randomized traffic, biased toward a few registers for collisions
    for (int n = 0; n < 600; n++) begin
      int hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
      drive(($urandom_range(0, 60) == 0),
            $urandom_range(0, 1), $urandom_range(0, hi), {$urandom, $urandom},
            $urandom_range(0, 1), $urandom_range(0, hi),
            $urandom_range(0, hi), $urandom_range(0, hi));
      check_all("rand");
      commit();
    end

    // small configuration: 4 ports, zero register at index 0
    drive(1, 0, 0, 0, 0, 0, 0, 0); commit();
    s_drive(1, 9, 32'h1234, 0, 0, 9, 9, 9, 9);
    s_check_all("s_w9_same");
    for (int p = 0; p < 4; p++) check($sformatf("s_w9_p%0d", p), 64'(s_rd[p*W2 +: W2]), 64'h1234);
    commit();
    s_drive(0, 0, 0, 0, 0, 9, 9, 9, 0);
    s_check_all("s_w9_next");
    check("s_r9_p0", 64'(s_rd[31:0]), 64'h1234);
    check("s_r0_p3", 64'(s_rd[127:96]), 64'd0);
    commit();
    s_drive(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 9, 0);
    s_check_all("s_zr_same");
    commit();
    s_drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    s_check_all("s_zr_next");
    check("s_zr_data", 64'(s_rd[31:0]), 64'd0);
    check("s_zr_any", 64'(s_ab), 64'd0);
    commit();
    for (int n = 0; n < 300; n++) begin
      s_drive($urandom_range(0, 1), $urandom_range(0, 5), $urandom,
              $urandom_range(0, 1), $urandom_range(0, 5),
              $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom_range(0, 15), $urandom_range(0, 5));
      s_check_all("s_rand");
      commit();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
